// File: rtl/pic16_pkg.sv
// Purpose : shared constants and the register-select decode for the PORTB block.
// Latency : n/a (package, no logic).
// Backpressure: n/a.
// Contents: file addresses of PORTB/TRISB, their reset values, and addr_decode().
package pic16_pkg;

    localparam logic [7:0] ADDR_PORTB = 8'h06;
    localparam logic [7:0] ADDR_TRISB = 8'h86;
    localparam logic [7:0] TRISB_RST  = 8'hFF;
    localparam logic [7:0] PORTB_RST  = 8'h00;

    // Number of clock edges after reset release before the synchronizer and
    // the RB0 history flop all hold real pad samples.
    localparam logic [1:0] SYNC_FILL  = 2'd3;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_PORTB = 2'd1,
        SEL_TRISB = 2'd2
    } reg_sel_e;

    function automatic reg_sel_e addr_decode(input logic [7:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_PORTB) sel = SEL_PORTB;
        if (addr == ADDR_TRISB) sel = SEL_TRISB;
        return sel;
    endfunction

endpackage

// File: rtl/port_b_sync.sv
// Purpose : two-flop synchronizer for the RB7..RB0 pads plus a previous-sample flop for RB0.
// Latency : sync_o follows pin_i after 2 clk edges; rb0_prev_o lags sync_o[0] by 1 edge.
// Backpressure: none, free-running every cycle.
// Ports   : clk, rst_n (sync, active-low), pin_i[7:0] async pads,
//           sync_o[7:0] synchronized pads, rb0_prev_o previous sync_o[0].
module port_b_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pin_i,
    output logic [7:0] sync_o,
    output logic       rb0_prev_o
);

    logic [7:0] meta_q;
    logic [7:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 8'h00;
            sync_q <= 8'h00;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q[0];
        end
    end

    assign sync_o     = sync_q;
    assign rb0_prev_o = prev_q;

endmodule

// File: rtl/port_b_ctrl.sv
// Purpose : PORTB/TRISB register pair with pad drive, RB0 edge interrupt and RB7:RB4 change interrupt.
// Latency : writes visible on pin_out/pin_oe 1 cycle later; rd_data 1 cycle after rd_en; pad to flag 3 cycles.
// Backpressure: none, every strobe is accepted in the cycle it is presented.
// Ports   : clk, rst_n (sync, active-low), wr_en/rd_en/addr/wr_data/rd_data register access,
//           pin_in/pin_out/pin_oe pads, intedg edge select, intf/rbif sticky flags with
//           intf_clr/rbif_clr clear strobes.
// Config  : define PORTB_CHANGE_INT_EN to build the RB7:RB4 change snapshot and rbif;
//           otherwise rbif is tied low and rbif_clr is ignored.
module port_b_ctrl
    import pic16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    input  logic [7:0] pin_in,
    output logic [7:0] pin_out,
    output logic [7:0] pin_oe,
    input  logic       intedg,
    input  logic       intf_clr,
    input  logic       rbif_clr,
    output logic       intf,
    output logic       rbif
);

    logic [7:0] sync_pin;
    logic       rb0_prev;

    port_b_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin_i      (pin_in),
        .sync_o     (sync_pin),
        .rb0_prev_o (rb0_prev)
    );

    reg_sel_e   sel;
    logic [7:0] latch_q, latch_d;
    logic [7:0] tris_q, tris_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       intf_q, intf_d;
    logic [1:0] fill_q, fill_d;
    logic       armed;
    logic       int_hit;

    assign sel = addr_decode(addr);

    // Flags are held off until the synchronizer and RB0 history contain real
    // pad samples, so the 0 -> pad transition during fill is never seen as a change.
    assign armed = (fill_q == SYNC_FILL);

    // Only consecutive synchronized RB0 samples are compared, so flipping
    // intedg with a steady pad cannot produce a hit.
    assign int_hit = armed && (intedg ? ( sync_pin[0] & ~rb0_prev)
                                      : (~sync_pin[0] &  rb0_prev));

    always_comb begin
        latch_d   = latch_q;
        tris_d    = tris_q;
        rd_data_d = rd_data_q;
        fill_d    = armed ? fill_q : fill_q + 2'd1;

        if (wr_en && (sel == SEL_PORTB)) latch_d = wr_data;
        if (wr_en && (sel == SEL_TRISB)) tris_d  = wr_data;

        // Read uses the registered (pre-write) values, so a coincident write
        // to the same address returns the old contents.
        if (rd_en) begin
            case (sel)
                SEL_PORTB: rd_data_d = (sync_pin & tris_q) | (latch_q & ~tris_q);
                SEL_TRISB: rd_data_d = tris_q;
                default:   rd_data_d = 8'h00;
            endcase
        end

        // Set has priority over a coincident clear.
        intf_d = int_hit | (intf_q & ~intf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_q   <= PORTB_RST;
            tris_q    <= TRISB_RST;
            rd_data_q <= 8'h00;
            intf_q    <= 1'b0;
            fill_q    <= 2'd0;
        end else begin
            latch_q   <= latch_d;
            tris_q    <= tris_d;
            rd_data_q <= rd_data_d;
            intf_q    <= intf_d;
            fill_q    <= fill_d;
        end
    end

`ifdef PORTB_CHANGE_INT_EN
    logic [3:0] snap_q, snap_d;
    logic       rbif_q, rbif_d;
    logic       rb_chg;

    // Output-mode bits are masked out so driving the latch never sets rbif.
    assign rb_chg = armed && (|((sync_pin[7:4] ^ snap_q) & tris_q[7:4]));

    always_comb begin
        snap_d = snap_q;
        if (rd_en && (sel == SEL_PORTB)) snap_d = sync_pin[7:4];
        rbif_d = rb_chg | (rbif_q & ~rbif_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q <= 4'h0;
            rbif_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            rbif_q <= rbif_d;
        end
    end

    assign rbif = rbif_q;
`else
    logic unused_rbif_clr;
    assign unused_rbif_clr = rbif_clr;
    assign rbif            = 1'b0;
`endif

    assign pin_out = latch_q;
    assign pin_oe  = ~tris_q;
    assign rd_data = rd_data_q;
    assign intf    = intf_q;

endmodule

// File: doc/port_b_ctrl.md
PORT_B_CTRL -- requirements
Module: port_b_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clk only.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 wr_en  in  1  register write strobe, one-cycle pulse.
REQ-005 rd_en  in  1  register read strobe, one-cycle pulse.
REQ-006 addr  in  8  bank-inclusive file address: 0x06 = PORTB, 0x86 = TRISB.
REQ-007 wr_data  in  8  write data.
REQ-008 rd_data  out  8  read data, registered.
REQ-009 pin_in  in  8  asynchronous RB7..RB0 pad levels.
REQ-010 pin_out  out  8  PORTB output latch, driven to pads.
REQ-011 pin_oe  out  8  per-bit drive enable, equal to ~TRISB.
REQ-012 intedg  in  1  RB0/INT edge select: 1 = rising, 0 = falling.
REQ-013 intf_clr, rbif_clr  in  1 each  flag clear strobes.
REQ-014 intf, rbif  out  1 each  sticky interrupt flags.

Function
REQ-015 pin_in SHALL pass through a two-flop synchronizer (sync_pin); every use of pad levels SHALL use the synchronized value.
REQ-016 A write with addr=0x06 SHALL load the latch from wr_data; pin_out SHALL update the cycle after wr_en.
REQ-017 A write with addr=0x86 SHALL load TRISB; pin_oe SHALL update the cycle after wr_en.
REQ-018 Reads SHALL have one-cycle latency: rd_data is valid the cycle after rd_en and holds until the next read.
REQ-019 A PORTB read SHALL return, per bit, sync_pin where TRISB=1 and the latch where TRISB=0.
REQ-020 A TRISB read SHALL return TRISB.
REQ-021 Reads and writes to any other address SHALL return 0x00 and leave all state unchanged.
REQ-022 When wr_en and rd_en coincide on the same address, the read SHALL return the pre-write value.
REQ-023 A PORTB read SHALL capture sync_pin[7:4] into the change snapshot.
REQ-024 rbif SHALL set in any cycle where a bit of RB7:RB4 with TRISB=1 differs from the snapshot; output bits SHALL never set rbif.
REQ-025 intf SHALL set on a synchronized RB0 edge of the polarity given by intedg, regardless of TRISB[0].
REQ-026 A change of intedg SHALL NOT by itself set intf; the edge detector compares consecutive sync_pin[0] samples only.
REQ-027 Flags SHALL stay set until their clear strobe; if a set condition and a clear occur in the same cycle, set SHALL win.

Reset
REQ-028 On rst_n=0 at a clock edge: latch=0x00, TRISB=0xFF, pin_out=0x00, pin_oe=0x00, rd_data=0x00, intf=0, rbif=0, snapshot=0x0, synchronizer and edge-history flops=0.
REQ-029 Reset SHALL override a coincident wr_en/rd_en; no flag SHALL set in the first two cycles after reset release due to synchronizer fill.

Configuration
REQ-030 Macro PORTB_CHANGE_INT_EN: when defined, REQ-023/024 SHALL be implemented.
REQ-031 When PORTB_CHANGE_INT_EN is undefined, rbif SHALL be tied 0, rbif_clr SHALL be ignored, the snapshot logic SHALL be absent, and all ports SHALL remain present.

Structure
REQ-032 Package pic16_pkg SHALL hold the address constants ADDR_PORTB=0x06 and ADDR_TRISB=0x86 and the reset constants TRISB_RST=0xFF and PORTB_RST=0x00.
REQ-033 Sub-module port_b_sync (8-bit two-flop synchronizer plus RB0 previous-sample flop) SHALL be instantiated once.

Verification
REQ-034 Reset, then read 0x86 -> rd_data=0xFF one cycle later; pin_oe=0x00; intf=rbif=0.
REQ-035 Write TRISB=0x0F, write PORTB=0xA5, pin_in=0x03, then read PORTB -> pin_out=0xA5, pin_oe=0xF0, rd_data=0xA3.
REQ-036 intedg=1, pin_in[0] 0->1 -> intf=1 three cycles after the pad change; pulse intf_clr with no edge -> intf=0; intf_clr coincident with a new edge -> intf stays 1.
REQ-037 TRISB=0xFF, read PORTB with pin_in=0x00, then set pin_in[6]=1 -> rbif=1; TRISB=0x0F and toggle pin_in[6] -> rbif not set (PORTB_CHANGE_INT_EN defined); with the macro undefined, rbif stays 0 throughout.
REQ-038 Simultaneous write and read of PORTB (old 0x11, new 0x22, TRISB=0x00) -> rd_data=0x11 and pin_out=0x22; access to 0x07 -> rd_data=0x00, no state change.
